vadd_float_lane_splitter: RTL
=============================

Name: vadd_float_lane_splitter

Overview:
- Upstream feeder for the float adder core.
- Accepts 512-bit AXI4-Stream words from the read-master path and serialises them into one 32-bit float lane per beat.
- Each beat drives two operand channels in lock-step: A carries the lane data, B carries the per-word sampled constant.
- Lanes with tkeep all zero are skipped without bubbles. TLAST is regenerated on the final emitted lane of a TLAST word.

Parameters:
- C_AXIS_TDATA_WIDTH, 512: input word width (multiple of C_ADDER_BIT_WIDTH).
- C_ADDER_BIT_WIDTH, 32: lane/operand width.
- LP_NUM_LANES (localparam), C_AXIS_TDATA_WIDTH/C_ADDER_BIT_WIDTH: lanes per word (16).

Ports:
- s_axis_aclk  in  1  single clock for all logic.
- s_axis_aresetn  in  1  asynchronous, active-low reset.
- ctrl_constant  in  C_ADDER_BIT_WIDTH  operand B value, sampled at word load.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  input word ready.
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  16 packed floats; lane i = bits [32i+31:32i].
- s_axis_tkeep  in  C_AXIS_TDATA_WIDTH/8  byte keep; lane i is live iff tkeep[4i+3:4i] != 0.
- s_axis_tlast  in  1  end of input packet.
- m_axis_a_tvalid / m_axis_a_tready  out/in  1  operand A handshake.
- m_axis_a_tdata  out  C_ADDER_BIT_WIDTH  lane data.
- m_axis_a_tlast  out  1  last lane of packet.
- m_axis_b_tvalid / m_axis_b_tready  out/in  1  operand B handshake.
- m_axis_b_tdata  out  C_ADDER_BIT_WIDTH  constant latched for the current word.
- m_axis_b_tlast  out  1  identical to m_axis_a_tlast.
- stat_lane_count  out  32  lanes issued on A since reset; wraps.
- stat_empty_last_err  out  1  sticky: a TLAST word with all-zero keep was dropped.

Behaviour:
Reset (async assert, sync release):
- buf_valid=0, both tvalid outputs=0, lane_idx=0, per-channel done flags=0.
- stat_lane_count=0, stat_empty_last_err=0, tdata/tlast outputs=0.
- Reset asserted mid-word discards the buffered word and any half-accepted lane. No output is produced for it.

States:
- IDLE (buf_valid=0): s_axis_tready=1.
- On s_axis handshake: latch tdata, tkeep, tlast and ctrl_constant into the buffer.
  - If any lane is live: set lane_idx = lowest live lane, go to ISSUE. The first beat is valid the cycle after load (1-cycle latency).
  - If keep is all zero: drop the word and stay in IDLE. If its tlast=1, set stat_empty_last_err.
- ISSUE: A and B tvalid are asserted together.
  - A tdata = lane lane_idx; B tdata = latched constant.
  - tlast = buf_tlast AND no live lane above lane_idx.

Handshake rules:
- Per channel, done_x is set on that channel's handshake.
- The beat completes in the cycle where (a_tready|done_a) and (b_tready|done_b) both hold.
- tvalid_x deasserts after that channel's own handshake until the beat completes. A and B never issue a new beat independently.
- tvalid never depends on tready. Data and tlast are held stable while tvalid is high.
- On beat completion: clear both done flags, stat_lane_count += 1, lane_idx = next-higher live lane (priority encode, no bubble).

Last live lane completes:
- s_axis_tready=1 in that same cycle (combinational from the m-side readies). This allows back-to-back reload with zero bubble.
- If an input word is accepted: reload and stay in ISSUE (or go to IDLE if that word's keep is all zero).
- Otherwise go to IDLE.
- Outside that case, s_axis_tready=0 in ISSUE.

Throughput and arithmetic:
- Sustained rate is 1 lane/cycle. A full word takes 16 cycles; reload adds no gap.
- Partial-nonzero lane keep is forwarded as a full 32-bit lane; no masking.
- stat_lane_count wraps modulo 2^32.

Decomposition:
- Shared package vadd_float_pkg holds: C_ADDER_BIT_WIDTH default, LP_NUM_LANES, lane-keep reduction function, lane-index width constant (clog2 of LP_NUM_LANES).
- One sub-module: vadd_float_lane_pick. It is a combinational priority encoder returning the lowest live lane index above a given index, plus a "none" flag. It is used for both the first-lane and next-lane searches.

Test Plan:
- Full word, keep=all ones, tlast=1, constant=0x3F800000, both readies=1:
  - A emits lanes 0..15 on 16 consecutive cycles starting 1 cycle after load.
  - B=0x3F800000 on every beat; tlast only on lane 15; stat_lane_count=16.
- Sparse keep 0x000F_0000_0000_F00F, tlast=1:
  - Exactly lanes 0, 3, 12 emitted back-to-back, no bubbles; tlast on lane 12.
- Skewed ready: a_tready=1 constantly, b_tready toggles 0/1:
  - A tvalid drops after its handshake and re-asserts only after B accepts.
  - Each lane appears exactly once per channel; the pair stays aligned.
- Two words back-to-back with both readies=1:
  - s_axis_tready pulses exactly when lane 15 of word 1 completes.
  - Lane 0 of word 2 follows the next cycle. Constant change between words appears only on word 2's beats.
- Keep=0 with tlast=1:
  - Word accepted in 1 cycle, no output beats, stat_empty_last_err=1 and sticky.
- s_axis_aresetn asserted after lane 5 of a word, mid-handshake with done_a=1:
  - Outputs go invalid immediately; counters and sticky clear.
  - Post-release, a new word streams starting at its lane 0.

Source files
------------

// File: rtl/vadd_float_pkg.sv
// Shared types and helpers for the float adder lane splitter.
package vadd_float_pkg;

    localparam int DEF_ADDER_BIT_WIDTH  = 32;
    localparam int DEF_AXIS_TDATA_WIDTH = 512;
    localparam int LP_NUM_LANES         = DEF_AXIS_TDATA_WIDTH / DEF_ADDER_BIT_WIDTH;
    localparam int LANE_IDX_W           = $clog2(LP_NUM_LANES);
    localparam int KEEP_W               = DEF_AXIS_TDATA_WIDTH / 8;
    localparam int KEEP_PER_LANE        = DEF_ADDER_BIT_WIDTH / 8;

    typedef logic [LP_NUM_LANES-1:0] lane_mask_t;
    typedef logic [LANE_IDX_W-1:0]   lane_idx_t;

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    // A lane is live if any of its keep bytes is set.
    function automatic lane_mask_t lane_live(input logic [KEEP_W-1:0] keep);
        lane_mask_t m;
        for (int i = 0; i < LP_NUM_LANES; i++) begin
            m[i] = |keep[i*KEEP_PER_LANE +: KEEP_PER_LANE];
        end
        return m;
    endfunction

endpackage

// File: rtl/vadd_float_lane_splitter_if.sv
// Stream bundle: one wide input word channel, two lock-stepped lane outputs.
interface vadd_float_lane_splitter_if #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_ADDER_BIT_WIDTH  = 32
);
    logic                            s_axis_tvalid;
    logic                            s_axis_tready;
    logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata;
    logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep;
    logic                            s_axis_tlast;

    logic                            m_axis_a_tvalid;
    logic                            m_axis_a_tready;
    logic [C_ADDER_BIT_WIDTH-1:0]    m_axis_a_tdata;
    logic                            m_axis_a_tlast;

    logic                            m_axis_b_tvalid;
    logic                            m_axis_b_tready;
    logic [C_ADDER_BIT_WIDTH-1:0]    m_axis_b_tdata;
    logic                            m_axis_b_tlast;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
        output s_axis_tready,
        output m_axis_a_tvalid, m_axis_a_tdata, m_axis_a_tlast,
        input  m_axis_a_tready,
        output m_axis_b_tvalid, m_axis_b_tdata, m_axis_b_tlast,
        input  m_axis_b_tready
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_a_tvalid, m_axis_a_tdata, m_axis_a_tlast,
        output m_axis_a_tready,
        input  m_axis_b_tvalid, m_axis_b_tdata, m_axis_b_tlast,
        output m_axis_b_tready
    );

endinterface

// File: rtl/vadd_float_lane_pick.sv
// Priority encoder: lowest live lane above (or at, when incl) a base index.
module vadd_float_lane_pick
    import vadd_float_pkg::*;
(
    input  lane_mask_t live,
    input  lane_idx_t  base,
    input  logic       incl,
    output lane_idx_t  idx,
    output logic       none
);

    always_comb begin
        idx  = '0;
        none = 1'b1;
        // Scan downward so the lowest qualifying lane is written last.
        for (int i = LP_NUM_LANES - 1; i >= 0; i--) begin
            if (live[i] && ((i > int'(base)) || (incl && i == int'(base)))) begin
                idx  = lane_idx_t'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vadd_float_lane_splitter.sv
// Serialises wide stream words into one float lane per beat on two
// lock-stepped operand channels (A = lane data, B = per-word constant).
module vadd_float_lane_splitter
    import vadd_float_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = DEF_AXIS_TDATA_WIDTH,
    parameter int C_ADDER_BIT_WIDTH  = DEF_ADDER_BIT_WIDTH
) (
    input  logic                         s_axis_aclk,
    input  logic                         s_axis_aresetn,
    input  logic [C_ADDER_BIT_WIDTH-1:0] ctrl_constant,
    vadd_float_lane_splitter_if.slave    bus,
    output logic [31:0]                  stat_lane_count,
    output logic                         stat_empty_last_err
);

    localparam int LP_LANES = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;

    state_t state, state_nxt;

    logic [LP_LANES-1:0][C_ADDER_BIT_WIDTH-1:0] buf_data;
    lane_mask_t                   buf_live;
    logic                         buf_tlast;
    logic [C_ADDER_BIT_WIDTH-1:0] buf_const;
    lane_idx_t                    lane_idx;
    logic                         done_a;
    logic                         done_b;

    lane_mask_t new_live;
    lane_idx_t  first_idx;
    logic       first_none;
    lane_idx_t  next_idx;
    logic       next_none;

    logic a_valid;
    logic b_valid;
    logic issue;
    logic beat_done;
    logic last_beat;
    logic in_ready;
    logic load;

    assign new_live = lane_live(bus.s_axis_tkeep);

    vadd_float_lane_pick u_first (
        .live (new_live),
        .base ('0),
        .incl (1'b1),
        .idx  (first_idx),
        .none (first_none)
    );

    vadd_float_lane_pick u_next (
        .live (buf_live),
        .base (lane_idx),
        .incl (1'b0),
        .idx  (next_idx),
        .none (next_none)
    );

    assign issue     = (state == S_ISSUE);
    assign beat_done = issue
                     && (bus.m_axis_a_tready || done_a)
                     && (bus.m_axis_b_tready || done_b);
    assign last_beat = beat_done && next_none;
    // Ready opens in the cycle the final lane retires, so reload has no gap.
    assign in_ready  = !issue || last_beat;
    assign load      = bus.s_axis_tvalid && in_ready;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (load && !first_none) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (last_beat) begin
                    state_nxt = (load && !first_none) ? S_ISSUE : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        a_valid             = issue && !done_a;
        b_valid             = issue && !done_b;
        bus.s_axis_tready   = in_ready;
        bus.m_axis_a_tvalid = a_valid;
        bus.m_axis_a_tdata  = buf_data[lane_idx];
        bus.m_axis_a_tlast  = buf_tlast && next_none;
        bus.m_axis_b_tvalid = b_valid;
        bus.m_axis_b_tdata  = buf_const;
        bus.m_axis_b_tlast  = buf_tlast && next_none;
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            buf_data            <= '0;
            buf_live            <= '0;
            buf_tlast           <= 1'b0;
            buf_const           <= '0;
            lane_idx            <= '0;
            done_a              <= 1'b0;
            done_b              <= 1'b0;
            stat_lane_count     <= '0;
            stat_empty_last_err <= 1'b0;
        end else begin
            if (load) begin
                buf_data  <= bus.s_axis_tdata;
                buf_live  <= new_live;
                buf_tlast <= bus.s_axis_tlast;
                buf_const <= ctrl_constant;
                lane_idx  <= first_idx;
            end else if (beat_done && !next_none) begin
                lane_idx  <= next_idx;
            end
            if (beat_done) begin
                done_a          <= 1'b0;
                done_b          <= 1'b0;
                stat_lane_count <= stat_lane_count + 32'd1;
            end else begin
                done_a <= done_a || (a_valid && bus.m_axis_a_tready);
                done_b <= done_b || (b_valid && bus.m_axis_b_tready);
            end
            if (load && first_none && bus.s_axis_tlast) begin
                stat_empty_last_err <= 1'b1;
            end
        end
    end

endmodule
